// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with frame debounce.
// Walks one active-low row at a time and samples the synchronized columns at
// the end of each row dwell. Every completed 16-key frame yields a candidate:
// exactly one key pressed, or none. A candidate that repeats for DEBOUNCE
// frames is committed.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   col_in     column lines, active-low, asynchronous to clk
//   row_out    row drive, active-low one-hot
//   key_code   last committed key (row*4 + col), holds after release
//   key_valid  one-cycle strobe when a new key is committed
//   key_down   high while a committed key is held
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned STEP_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  logic [3:0]        col_meta;
  logic [3:0]        col_sync;
  logic [STEP_W-1:0] step;
  logic [1:0]        row;
  logic [15:0]       snap;
  logic              cand_vld;
  logic [3:0]        cand_key;
  logic [3:0]        deb_cnt;

  logic        tick;
  logic        frame_end;
  logic [1:0]  row_nxt;
  logic [15:0] snap_next;
  logic        new_vld;
  logic [3:0]  new_key;
  logic        same_cand;
  logic [3:0]  deb_next;
  logic        differs;
  logic        commit;

  // Next-frame snapshot, candidate decode and commit decision.
  always_comb begin
    tick      = (step == STEP_LAST);
    frame_end = tick && (row == 2'd3);
    row_nxt   = row + 2'd1;

    // The row being closed this tick is folded in so the frame-end decode
    // sees the complete 16-bit picture.
    snap_next = snap;
    snap_next[{row, 2'b00} +: 4] = ~col_sync;

    // Exactly one bit set is a clean key; zero or several is rejected.
    new_vld = (snap_next != 16'd0) && ((snap_next & (snap_next - 16'd1)) == 16'd0);
    new_key = 4'd0;
    if (new_vld) begin
      for (int i = 0; i < 16; i++) begin
        if (snap_next[i]) new_key = 4'(i);
      end
    end

    same_cand = (new_vld == cand_vld) && (!new_vld || (new_key == cand_key));
    if (same_cand) deb_next = (deb_cnt < DEB_MAX) ? (deb_cnt + 4'd1) : deb_cnt;
    else           deb_next = 4'd1;

    // Committed state is key_code while key_down, otherwise none.
    differs = (new_vld != key_down) || (new_vld && (new_key != key_code));
    commit  = frame_end && (deb_next == DEB_MAX) && differs;
  end

  // Column synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Row stepping and snapshot capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step    <= '0;
      row     <= 2'd0;
      row_out <= 4'b1110;
      snap    <= 16'd0;
    end else if (tick) begin
      step    <= '0;
      row     <= row_nxt;
      row_out <= ~(4'b0001 << row_nxt);
      snap    <= snap_next;
    end else begin
      step    <= step + STEP_W'(1);
    end
  end

  // Frame debounce and committed key outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_vld  <= 1'b0;
      cand_key  <= 4'd0;
      deb_cnt   <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        cand_vld <= new_vld;
        cand_key <= new_key;
        deb_cnt  <= deb_next;
      end
      if (commit) begin
        if (new_vld) begin
          key_code  <= new_key;
          key_down  <= 1'b1;
          key_valid <= 1'b1;
        end else begin
          key_down  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3.
// A behavioural key matrix pulls column lines low for pressed keys on the
// currently driven row.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;
  localparam int FRAME = 16;
  localparam int LAT   = 4 * FRAME + 3;

  logic        clk;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int         checks;
  int         errors;
  int         pulses;
  logic [3:0] last_code;
  logic       last_down;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key shorts its column to the active-low row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4 + c]) col_in[c] = 1'b0;
      end
    end
  end

  // Pulse monitor.
  initial pulses = 0;
  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      last_code = key_code;
      last_down = key_down;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input int p0, output int cyc);
    cyc = 0;
    while (pulses == p0 && cyc < LAT) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  logic [3:0] rot [4];
  int p0;
  int cyc;

  initial begin
    checks = 0;
    errors = 0;
    last_code = 4'd0;
    last_down = 1'b0;
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
    rst  = 1'b0;
    keys = 16'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row", 32'(row_out), 32'(4'b1110));
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_down", 32'(key_down), 32'd0);

    // Row rotation every SCAN_DIV cycles
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("rotate", 32'(row_out), 32'(rot[k % 4]));
      repeat (SCAN_DIV) @(negedge clk);
    end
    repeat (4 * FRAME) @(negedge clk);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_down", 32'(key_down), 32'd0);

    // Single press of key 9 (row 2, col 1)
    p0 = pulses;
    keys = 16'h0200;
    wait_pulse(p0, cyc);
    check("press_seen", 32'(pulses != p0), 32'd1);
    check("press_code", 32'(last_code), 32'd9);
    check("press_down", 32'(last_down), 32'd1);
    repeat (6 * FRAME - cyc) @(negedge clk);
    check("press_one_pulse", 32'(pulses - p0), 32'd1);
    check("press_held", 32'(key_down), 32'd1);

    // Release
    p0 = pulses;
    keys = 16'd0;
    cyc = 0;
    while (key_down && cyc < LAT) begin
      @(negedge clk);
      cyc++;
    end
    check("release_down", 32'(key_down), 32'd0);
    check("release_code", 32'(key_code), 32'd9);
    repeat (2 * FRAME) @(negedge clk);
    check("release_no_pulse", 32'(pulses - p0), 32'd0);

    // Key 5 bouncing every frame
    p0 = pulses;
    for (int f = 0; f < 8; f++) begin
      keys = (f % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (FRAME) @(negedge clk);
    end
    keys = 16'd0;
    repeat (5 * FRAME) @(negedge clk);
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    check("bounce_down", 32'(key_down), 32'd0);

    // Keys 0 and 15 together are rejected, then key 0 alone commits
    p0 = pulses;
    keys = 16'h8001;
    repeat (6 * FRAME) @(negedge clk);
    check("multi_no_pulse", 32'(pulses - p0), 32'd0);
    check("multi_down", 32'(key_down), 32'd0);
    keys = 16'h0001;
    wait_pulse(p0, cyc);
    check("multi_rel_seen", 32'(pulses != p0), 32'd1);
    check("multi_rel_code", 32'(last_code), 32'd0);
    check("multi_rel_down", 32'(last_down), 32'd1);

    // Key 7 replaces key 0; reset lands in frame 2 before it can commit
    p0 = pulses;
    keys = 16'h0080;
    repeat (24) @(negedge clk);
    check("pre_rst_down", 32'(key_down), 32'd1);
    check("pre_rst_no_pulse", 32'(pulses - p0), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_row", 32'(row_out), 32'(4'b1110));
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_down", 32'(key_down), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p0 = pulses;
    wait_pulse(p0, cyc);
    check("post_rst_latency", 32'(cyc), 32'(DEBOUNCE * FRAME));
    check("post_rst_code", 32'(last_code), 32'd7);
    check("post_rst_down", 32'(last_down), 32'd1);
    repeat (2 * FRAME) @(negedge clk);
    check("post_rst_one_pulse", 32'(pulses - p0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
